rat_restore_walker: RTL and testbench
=====================================

Name: rat_restore_walker

Overview:
- Commit-side initiator of the RAT restore interface: it drives `commit_rat_restore_new_phy_id`, `commit_rat_restore_old_phy_id` and `commit_rat_restore_map`.
- Holds an in-order circular log of rename records (new phy id, previous phy id) pushed by rename and retired by commit.
- On a pipeline flush it walks the log youngest-first, issuing one restore per cycle to roll the RAT back to the committed mapping.
- Sits between rename/commit and the rat module.

Parameters:
- DEPTH, 16, log capacity in entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), index width; the head and tail pointers are PTR_W+1 bits, the extra MSB being the wrap bit.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rename_walker_push  in  1  append one rename record.
- rename_walker_new_phy_id  in  `PHY_REG_ID_WIDTH  newly allocated phy id.
- rename_walker_old_phy_id  in  `PHY_REG_ID_WIDTH  phy id previously mapped to the same arch reg.
- rename_walker_old_phy_id_valid  in  1  old mapping exists; 0 for arch x0 / no destination.
- walker_rename_full  out  1  log cannot accept a push.
- commit_walker_pop  in  1  oldest record retired.
- walker_commit_head_old_phy_id  out  `PHY_REG_ID_WIDTH  old phy id of the oldest record, used by commit for release.
- walker_commit_head_valid  out  1  log non-empty and head record's old id valid.
- flush_walker_start  in  1  begin rollback.
- commit_rat_restore_new_phy_id  out  `PHY_REG_ID_WIDTH  phy id to invalidate.
- commit_rat_restore_old_phy_id  out  `PHY_REG_ID_WIDTH  phy id to make visible again.
- commit_rat_restore_map  out  1  restore strobe.
- walker_busy  out  1  walk in progress (WALK or DONE).
- walker_done  out  1  single-cycle pulse when rollback finishes.
- walker_count  out  PTR_W+1  occupied entries, range 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - head=tail=0 and state=IDLE.
  - All outputs 0, except walker_rename_full=0.
  - Entry storage need not be cleared.
- Pointer rules:
  - count = tail - head, modulo 2^(PTR_W+1).
  - empty when count==0; full when count==DEPTH, i.e. index bits equal and wrap bits differ.
- IDLE state:
  - Push is accepted only when !full; it writes at tail[PTR_W-1:0] and then increments tail.
  - Pop is accepted only when !empty and increments head.
  - Push and pop in the same cycle are both accepted; count is unchanged. When full, a same-cycle pop does not enable the push (full is a registered-state decision).
  - Push while full and pop while empty are ignored; state is unchanged.
  - walker_rename_full = full.
- IDLE, flush_walker_start=1:
  - Any same-cycle push or pop is discarded.
  - Next state is WALK if count!=0, otherwise DONE.
- WALK state (Moore outputs from registered state):
  - The youngest entry is e = tail-1.
  - commit_rat_restore_new_phy_id = e.new and commit_rat_restore_old_phy_id = e.old.
  - commit_rat_restore_map = e.old_valid; an entry with old_valid=0 still consumes one cycle with map=0.
  - tail decrements every cycle. When tail-1 == head (last entry), next state is DONE.
- DONE state: lasts one cycle with walker_done=1 and restore_map=0, then returns to IDLE with the log empty.
- During WALK/DONE:
  - walker_busy=1 and walker_rename_full=1.
  - push, pop and flush_walker_start are ignored.
- Latency:
  - Start in cycle N gives the first restore in cycle N+1.
  - With k entries, the walk lasts k cycles; done is asserted in cycle N+k+1.
  - With k=0, done is asserted in cycle N+1.
- Head outputs:
  - walker_commit_head_old_phy_id = entry[head].old.
  - walker_commit_head_valid = !empty && entry[head].old_valid && state==IDLE.
- Wrap-around: pointers wrap modulo 2^(PTR_W+1) during both push and walk.
- Reset mid-walk aborts immediately: restore_map=0 and state=IDLE.

Optional Feature:
- Macro: RAT_RESTORE_WALKER_CHECK_EN.
- When defined, simulation-only immediate assertions $error and $finish on any of:
  - push while full in IDLE;
  - pop while empty;
  - push/pop/start asserted while busy;
  - count > DEPTH.
- When undefined, no checking logic is generated and the illegal requests are silently ignored as specified above.

Test Plan:
- Reset, release rst -> walker_count=0, full=0, busy=0, restore_map=0, done=0.
- Push 3 records (new=32/old=1, new=33/old=2, new=34/old=3) then start -> restore (34,3), (33,2), (32,1) on 3 consecutive cycles, done 1 cycle later, count=0.
- Push 16 records -> full=1. 17th push ignored, count=16. Pop+push in the same cycle while full -> count 15. Pop+push when count=15 -> count stays 15.
- Push entry with old_valid=0 between two valid entries, start -> middle walk cycle has restore_map=0; total walk 3 cycles.
- Start with empty log -> done asserted on the next cycle, no restore_map ever.
- Push 10, pop 8, push 12 (wrap) then start; drop rst after 5 walk cycles -> outputs zero immediately, count=0, subsequent push accepted.

Source files
------------

// File: rtl/rat_restore_walker.sv
// Circular rename log feeding RAT restores: youngest-first rollback walk on flush.
// Optional simulation checks are enabled by defining RAT_RESTORE_WALKER_CHECK_EN.
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 7
`endif

module rat_restore_walker #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rename_walker_push,
  input  logic [`PHY_REG_ID_WIDTH-1:0] rename_walker_new_phy_id,
  input  logic [`PHY_REG_ID_WIDTH-1:0] rename_walker_old_phy_id,
  input  logic                         rename_walker_old_phy_id_valid,
  output logic                         walker_rename_full,
  input  logic                         commit_walker_pop,
  output logic [`PHY_REG_ID_WIDTH-1:0] walker_commit_head_old_phy_id,
  output logic                         walker_commit_head_valid,
  input  logic                         flush_walker_start,
  output logic [`PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_phy_id,
  output logic [`PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_phy_id,
  output logic                         commit_rat_restore_map,
  output logic                         walker_busy,
  output logic                         walker_done,
  output logic [PTR_W:0]               walker_count
);

  localparam int unsigned W = `PHY_REG_ID_WIDTH;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [PTR_W:0]   tail_m1;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  logic [W-1:0]     new_mem [DEPTH];
  logic [W-1:0]     old_mem [DEPTH];
  logic [DEPTH-1:0] ov_mem;

  assign count   = tail - head;
  assign tail_m1 = tail - PTR_ONE;
  assign empty   = (tail == head);
  assign full    = (tail[PTR_W] != head[PTR_W]) &&
                   (tail[PTR_W-1:0] == head[PTR_W-1:0]);

  // A flush in IDLE swallows any same-cycle push/pop; full/empty come from registered pointers only.
  assign push_ok = (state == S_IDLE) && !flush_walker_start && rename_walker_push && !full;
  assign pop_ok  = (state == S_IDLE) && !flush_walker_start && commit_walker_pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_walker_start) begin
            state <= empty ? S_DONE : S_WALK;
          end else begin
            if (push_ok) tail <= tail + PTR_ONE;
            if (pop_ok)  head <= head + PTR_ONE;
          end
        end
        S_WALK: begin
          tail <= tail_m1;
          if (tail_m1 == head) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        new_mem[i] <= '0;
        old_mem[i] <= '0;
      end
      ov_mem <= '0;
    end else if (push_ok) begin
      new_mem[tail[PTR_W-1:0]] <= rename_walker_new_phy_id;
      old_mem[tail[PTR_W-1:0]] <= rename_walker_old_phy_id;
      ov_mem[tail[PTR_W-1:0]]  <= rename_walker_old_phy_id_valid;
    end
  end

  always_comb begin
    commit_rat_restore_new_phy_id = '0;
    commit_rat_restore_old_phy_id = '0;
    commit_rat_restore_map        = 1'b0;
    if (state == S_WALK) begin
      commit_rat_restore_new_phy_id = new_mem[tail_m1[PTR_W-1:0]];
      commit_rat_restore_old_phy_id = old_mem[tail_m1[PTR_W-1:0]];
      commit_rat_restore_map        = ov_mem[tail_m1[PTR_W-1:0]];
    end
  end

  always_comb begin
    walker_busy                   = (state == S_WALK) || (state == S_DONE);
    walker_done                   = (state == S_DONE);
    walker_rename_full            = walker_busy || full;
    walker_count                  = count;
    walker_commit_head_old_phy_id = old_mem[head[PTR_W-1:0]];
    walker_commit_head_valid      = (state == S_IDLE) && !empty && ov_mem[head[PTR_W-1:0]];
  end

`ifdef RAT_RESTORE_WALKER_CHECK_EN
  always @(posedge clk) begin
    if (rst) begin
      assert (!((state == S_IDLE) && !flush_walker_start && rename_walker_push && full))
      else begin $error("rat_restore_walker: push while full"); $finish; end
      assert (!((state == S_IDLE) && !flush_walker_start && commit_walker_pop && empty))
      else begin $error("rat_restore_walker: pop while empty"); $finish; end
      assert (!((state != S_IDLE) &&
                (rename_walker_push || commit_walker_pop || flush_walker_start)))
      else begin $error("rat_restore_walker: request while busy"); $finish; end
      assert (!(32'(count) > DEPTH))
      else begin $error("rat_restore_walker: count exceeds depth"); $finish; end
    end
  end
`endif

endmodule

// File: tb/tb_rat_restore_walker.sv
// Bench for rat_restore_walker: vector table, directed corner cases and a queue-based random model.
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 7
`endif

module tb_rat_restore_walker;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int W     = `PHY_REG_ID_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push = 1'b0, pop = 1'b0, start = 1'b0, ov = 1'b0;
  logic [W-1:0] new_id = '0, old_id = '0;
  logic full, head_valid, rmap, busy, done;
  logic [W-1:0] head_old, r_new, r_old;
  logic [PTR_W:0] count;

  rat_restore_walker #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .rename_walker_push(push), .rename_walker_new_phy_id(new_id),
    .rename_walker_old_phy_id(old_id), .rename_walker_old_phy_id_valid(ov),
    .walker_rename_full(full), .commit_walker_pop(pop),
    .walker_commit_head_old_phy_id(head_old), .walker_commit_head_valid(head_valid),
    .flush_walker_start(start),
    .commit_rat_restore_new_phy_id(r_new), .commit_rat_restore_old_phy_id(r_old),
    .commit_rat_restore_map(rmap), .walker_busy(busy), .walker_done(done),
    .walker_count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: log as a queue, youngest at the back; walk pops from the back.
  typedef struct { logic [W-1:0] nw; logic [W-1:0] od; logic v; } rec_t;
  rec_t log_q[$];
  bit   m_walk, m_done;

  function automatic void model_reset();
    log_q.delete();
    m_walk = 0;
    m_done = 0;
  endfunction

  function automatic void model_update(bit p, logic [W-1:0] n, logic [W-1:0] o, bit v,
                                       bit pp, bit st);
    rec_t r;
    if (m_done) m_done = 0;
    else if (m_walk) begin
      void'(log_q.pop_back());
      if (log_q.size() == 0) begin m_walk = 0; m_done = 1; end
    end else if (st) begin
      if (log_q.size() > 0) m_walk = 1; else m_done = 1;
    end else begin
      bit was_full  = (log_q.size() == DEPTH);
      bit was_empty = (log_q.size() == 0);
      if (pp && !was_empty) void'(log_q.pop_front());
      if (p && !was_full) begin r.nw = n; r.od = o; r.v = v; log_q.push_back(r); end
    end
  endfunction

  task automatic check_model(input string tag);
    bit b = m_walk || m_done;
    chk({tag, ".count"}, 32'(count), 32'(log_q.size()));
    chk({tag, ".full"},  32'(full),  32'(b || log_q.size() == DEPTH));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(m_done));
    chk({tag, ".map"},   32'(rmap),  m_walk ? 32'(log_q[$].v)  : 32'd0);
    chk({tag, ".rnew"},  32'(r_new), m_walk ? 32'(log_q[$].nw) : 32'd0);
    chk({tag, ".rold"},  32'(r_old), m_walk ? 32'(log_q[$].od) : 32'd0);
    chk({tag, ".hvalid"}, 32'(head_valid), 32'(!b && log_q.size() > 0 && log_q[0].v));
    if (!b && log_q.size() > 0) chk({tag, ".hold"}, 32'(head_old), 32'(log_q[0].od));
  endtask

  // Called at a falling edge: drive, clock, advance model, compare at next falling edge.
  task automatic step(input bit p, input logic [W-1:0] n, input logic [W-1:0] o, input bit v,
                      input bit pp, input bit st, input string tag);
    push = p; new_id = n; old_id = o; ov = v; pop = pp; start = st;
    @(posedge clk);
    model_update(p, n, o, v, pp, st);
    @(negedge clk);
    push = 0; pop = 0; start = 0;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; push = 0; pop = 0; start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  typedef struct {
    bit p; logic [W-1:0] n; logic [W-1:0] o; bit v; bit pp; bit st;
    int cnt; bit f; bit b; bit d; bit m; int rn; int ro;
  } vec_t;
  vec_t vec[20];

  initial begin
    vec[0]  = '{1, 32, 1, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0};
    vec[1]  = '{1, 33, 2, 1, 0, 0,  2, 0, 0, 0, 0,  0, 0};
    vec[2]  = '{1, 34, 3, 1, 0, 0,  3, 0, 0, 0, 0,  0, 0};
    vec[3]  = '{0,  0, 0, 0, 0, 1,  3, 1, 1, 0, 1, 34, 3};
    vec[4]  = '{1, 50, 9, 1, 0, 0,  2, 1, 1, 0, 1, 33, 2};
    vec[5]  = '{0,  0, 0, 0, 1, 1,  1, 1, 1, 0, 1, 32, 1};
    vec[6]  = '{0,  0, 0, 0, 0, 0,  0, 1, 1, 1, 0,  0, 0};
    vec[7]  = '{0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    vec[8]  = '{1, 40, 5, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0};
    vec[9]  = '{1, 41, 0, 0, 0, 0,  2, 0, 0, 0, 0,  0, 0};
    vec[10] = '{1, 42, 6, 1, 0, 0,  3, 0, 0, 0, 0,  0, 0};
    vec[11] = '{0,  0, 0, 0, 0, 1,  3, 1, 1, 0, 1, 42, 6};
    vec[12] = '{0,  0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 41, 0};
    vec[13] = '{0,  0, 0, 0, 0, 0,  1, 1, 1, 0, 1, 40, 5};
    vec[14] = '{0,  0, 0, 0, 0, 0,  0, 1, 1, 1, 0,  0, 0};
    vec[15] = '{0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    vec[16] = '{0,  0, 0, 0, 0, 1,  0, 1, 1, 1, 0,  0, 0};
    vec[17] = '{0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    vec[18] = '{1,  1, 2, 1, 1, 1,  0, 1, 1, 1, 0,  0, 0};
    vec[19] = '{0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};

    // Reset state
    do_reset();
    chk("rst.count", 32'(count), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.map", 32'(rmap), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.hvalid", 32'(head_valid), 0);
    chk("rst.hold", 32'(head_old), 0);

    // Vector table: outputs expected in the cycle after each row's inputs
    foreach (vec[i]) begin
      push = vec[i].p; new_id = vec[i].n; old_id = vec[i].o; ov = vec[i].v;
      pop = vec[i].pp; start = vec[i].st;
      @(posedge clk);
      @(negedge clk);
      push = 0; pop = 0; start = 0;
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vec[i].cnt));
      chk($sformatf("vec%0d.full", i),  32'(full),  32'(vec[i].f));
      chk($sformatf("vec%0d.busy", i),  32'(busy),  32'(vec[i].b));
      chk($sformatf("vec%0d.done", i),  32'(done),  32'(vec[i].d));
      chk($sformatf("vec%0d.map", i),   32'(rmap),  32'(vec[i].m));
      chk($sformatf("vec%0d.rnew", i),  32'(r_new), 32'(vec[i].rn));
      chk($sformatf("vec%0d.rold", i),  32'(r_old), 32'(vec[i].ro));
    end

    // Fill to capacity, overflow push, pop+push at and below full
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1, W'(i + 64), W'(i + 1), 1, 0, 0, "fill");
    chk("full16.full", 32'(full), 1);
    step(1, 7'd99, 7'd99, 1, 0, 0, "ovf");
    chk("ovf.count", 32'(count), 16);
    step(1, 7'd98, 7'd98, 1, 1, 0, "pp_full");
    chk("pp_full.count", 32'(count), 15);
    step(1, 7'd97, 7'd97, 0, 1, 0, "pp_15");
    chk("pp_15.count", 32'(count), 15);
    step(0, 0, 0, 0, 1, 0, "pop_empty_chk");

    // Wrap-around walk aborted by asynchronous reset
    do_reset();
    for (int i = 0; i < 10; i++) step(1, W'(i + 10), W'(i + 1), 1, 0, 0, "w_push");
    for (int i = 0; i < 8; i++)  step(0, 0, 0, 0, 1, 0, "w_pop");
    for (int i = 0; i < 12; i++) step(1, W'(i + 80), W'(i + 20), i[0], 0, 0, "w_push2");
    chk("wrap.count", 32'(count), 14);
    step(0, 0, 0, 0, 0, 1, "w_start");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, "w_walk");
    #2 rst = 0;
    #1;
    chk("abort.map", 32'(rmap), 0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.count", 32'(count), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.full", 32'(full), 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    step(1, 7'd5, 7'd6, 1, 0, 0, "post_abort");
    chk("post_abort.count", 32'(count), 1);

    // Random legal traffic against the queue model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit idle = !(m_walk || m_done);
      bit p  = idle && ($urandom_range(0, 99) < 55) && (log_q.size() < DEPTH);
      bit pp = idle && ($urandom_range(0, 99) < 40) && (log_q.size() > 0);
      bit st = idle && ($urandom_range(0, 99) < 4);
      step(p, W'($urandom), W'($urandom), 1'($urandom), pp, st, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
